// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the iterative multiplier.
// The optional BOOTH_MUL_EARLY_TERM_EN macro is consumed by booth_iter_mul.
package booth_pkg;

  typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} booth_digit_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mul_state_e;

  // Decode the triple {b[2k+1], b[2k], b[2k-1]} into a signed multiple of A.
  function automatic booth_digit_e booth_decode(input logic [2:0] i_trip);
    booth_digit_e w_dig;
    case (i_trip)
      3'b001, 3'b010: w_dig = BD_P1;
      3'b011:         w_dig = BD_P2;
      3'b100:         w_dig = BD_M2;
      3'b101, 3'b110: w_dig = BD_M1;
      default:        w_dig = BD_ZERO;
    endcase
    return w_dig;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: selects 0, +-A or +-2A of the
// WIDTH+2-bit extended multiplicand.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mcand,
  input  booth_digit_e     i_digit,
  input  logic             i_sign,
  output logic [WIDTH+1:0] o_pp
);

  logic [WIDTH+1:0] w_ext;
  logic [WIDTH+1:0] w_dbl;

  assign w_ext = {{2{i_sign & i_mcand[WIDTH-1]}}, i_mcand};
  assign w_dbl = {w_ext[WIDTH:0], 1'b0};

  always_comb begin
    o_pp = '0;
    case (i_digit)
      BD_P1:   o_pp = w_ext;
      BD_P2:   o_pp = w_dbl;
      BD_M1:   o_pp = -w_ext;
      BD_M2:   o_pp = -w_dbl;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier, PP_PER_CYCLE digits per clock, valid/ready on both sides.
// Define BOOTH_MUL_EARLY_TERM_EN to finish as soon as all remaining digits are zero.
module booth_iter_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PP_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned ITER = (NDIG + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned SH   = 2 * PP_PER_CYCLE;
  // The two accumulator bits above 2*WIDTH can never reach p, so they are not kept.
  localparam int unsigned AW   = 2 * WIDTH;

  mul_state_e       r_state;
  logic [WIDTH-1:0] r_a;
  logic             r_sign;
  logic [EW:0]      r_mb;  // extended multiplier with guard bit at [0]
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [EW-1:0]    w_pp [PP_PER_CYCLE];
  logic [AW-1:0]    w_acc_next;
  logic [EW:0]      w_mb_next;
  logic             w_ext;
  logic             w_last;

  for (genvar g = 0; g < PP_PER_CYCLE; g++) begin : g_pp
    booth_digit_e w_dig;
    assign w_dig = booth_decode(r_mb[2*g+2:2*g]);
    booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
      .i_mcand (r_a),
      .i_digit (w_dig),
      .i_sign  (r_sign),
      .o_pp    (w_pp[g])
    );
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < int'(PP_PER_CYCLE); j++) begin
      w_acc_next = w_acc_next + ({{(AW-EW){w_pp[j][EW-1]}}, w_pp[j]}
                                 << (int'(SH) * int'(r_cnt) + 2 * j));
    end
  end

  assign w_ext     = r_mb[EW];
  assign w_mb_next = {{SH{w_ext}}, r_mb[EW:SH]};

`ifdef BOOTH_MUL_EARLY_TERM_EN
  assign w_last = (r_cnt == CW'(ITER - 1)) || (w_mb_next == {(EW+1){w_ext}});
`else
  assign w_last = (r_cnt == CW'(ITER - 1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_sign      <= 1'b0;
      r_mb        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_sign     <= sign;
            r_mb       <= {{2{sign & b[WIDTH-1]}}, b, 1'b0};
            r_cnt      <= '0;
            r_acc      <= '0;
            r_state    <= ST_BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_next;
          r_mb  <= w_mb_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_acc;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Directed and table-driven bench for booth_iter_mul at WIDTH=32, PP_PER_CYCLE=2.
module tb_booth_iter_mul;

  localparam int W    = 32;
  localparam int PP   = 2;
  localparam int NDIG = W / 2 + 1;
  localparam int ITER = (NDIG + PP - 1) / PP;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          sign      = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] p;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_iter_mul #(.WIDTH(W), .PP_PER_CYCLE(PP)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{ma[W-1]}}, ma} : {32'b0, ma};
    eb = s ? {{32{mb[W-1]}}, mb} : {32'b0, mb};
    return ea * eb;
  endfunction

  // Cycles from accept edge to out_valid; shorter only in the early-termination build.
  function automatic int exp_lat(input logic [W-1:0] bb, input logic s);
    logic [W+2:0] mb;
    logic         e;
    int           n;
    e  = s & bb[W-1];
    mb = {{2{e}}, bb, 1'b0};
    n  = 0;
    do begin
      n++;
      mb = {{(2*PP){e}}, mb[W+2:2*PP]};
    end while (n < ITER && mb != {(W+3){e}});
`ifdef BOOTH_MUL_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? ITER : 0;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                        input string tag, output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    a = oa; b = ob; sign = os; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sign = ~os;
    check({tag, " busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = p;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat;

    vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0006, 1'b0, 64'd42};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0003, 1'b1, 64'd15};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE};
    vecs[8]  = '{32'h1234_5678, 32'h0000_0000, 1'b0, 64'd0};
    vecs[9]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[11] = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[12] = '{32'h0000_0003, 32'h4000_0000, 1'b0, 64'h0000_0000_C000_0000};
    vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};

    // Reset values
    #12;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst p", p, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Table vectors with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i), res, lat);
      check($sformatf("vec%0d p", i), res, vecs[i].p);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].b, vecs[i].s)));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pop out_valid", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d pop in_ready", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: DONE holds with p stable and new operands ignored
    out_ready = 1'b0;
    run_op(32'd7, 32'd6, 1'b0, "bp", res, lat);
    check("bp p", res, 64'd42);
    check("bp latency", 64'(lat), 64'(exp_lat(32'd6, 1'b0)));
    a = 32'd100; b = 32'd100; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp hold%0d p", c), p, 64'd42);
      check($sformatf("bp hold%0d in_ready", c), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release busy", 64'(busy), 64'd0);

    // Reset in the 4th BUSY cycle discards the operation
    @(negedge clk);
    a = 32'd9; b = 32'd9; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("mid rst in_ready", 64'(in_ready), 64'd1);
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst p", p, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("mid rst no output", 64'(lat), 64'd0);
    run_op(32'd3, 32'd5, 1'b0, "post rst", res, lat);
    check("post rst p", res, 64'd15);
    check("post rst latency", 64'(lat), 64'(exp_lat(32'd5, 1'b0)));
    @(posedge clk);

    // Random operands against the reference product
    for (int i = 0; i < 120; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = $urandom;
      rb = (i % 4 == 0) ? (32'($urandom) >> $urandom_range(31, 0)) : 32'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, $sformatf("rnd%0d", i), res, lat);
      check($sformatf("rnd%0d p a=%h b=%h s=%0d", i, ra, rb, rs), res, model(ra, rb, rs));
      check($sformatf("rnd%0d latency", i), 64'(lat), 64'(exp_lat(rb, rs)));
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
